// File: rtl/axis_pkg.sv
// Shared types and default constants for the AXI-Stream slave stage.
package axis_pkg;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tstrb;
        logic [3:0]  tkeep;
        logic [1:0]  tuser;
        logic        tlast;
    } axis_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN
    } axis_slv_state_t;

    localparam int         AXIS_FIFO_DEPTH_DEFAULT     = 8;
    localparam logic [7:0] AXIS_BK_RDY_TIMEOUT_DEFAULT = 8'd5;

endpackage

// File: rtl/axis_slave_fifo.sv
// First-word-fall-through FIFO of AXIS beats; the head is zero when empty.
module axis_slave_fifo
    import axis_pkg::*;
#(
    parameter int DEPTH = AXIS_FIFO_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  axis_beat_t    push_beat,
    input  logic          pop,
    output logic [CW-1:0] count,
    output axis_beat_t    head
);

    axis_beat_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_beat;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/axis_slave.sv
// AXIS slave stage: FIFO-buffered, one frame at a time, with beat count and done pulse.
// Define AXIS_SLAVE_TIMEOUT_EN to enable the backend stall detector driving bk_nordy.
module axis_slave
    import axis_pkg::*;
#(
    parameter int         FIFO_DEPTH     = AXIS_FIFO_DEPTH_DEFAULT,
    parameter logic [7:0] BK_RDY_TIMEOUT = AXIS_BK_RDY_TIMEOUT_DEFAULT
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        axis_tvalid,
    input  logic [31:0] axis_tdata,
    input  logic [3:0]  axis_tstrb,
    input  logic [3:0]  axis_tkeep,
    input  logic [1:0]  axis_tuser,
    input  logic        axis_tlast,
    output logic        axis_tready,
    output logic        bk_valid,
    output logic [31:0] bk_data,
    output logic [3:0]  bk_tstrb,
    output logic [3:0]  bk_tkeep,
    output logic [1:0]  bk_user,
    output logic        bk_last,
    input  logic        bk_ready,
    output logic        bk_done,
    output logic [7:0]  bk_beat_cnt,
    output logic        bk_nordy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    axis_slv_state_t state;
    axis_slv_state_t state_next;
    axis_beat_t      in_beat;
    axis_beat_t      head;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;

    assign in_beat = '{tdata: axis_tdata, tstrb: axis_tstrb, tkeep: axis_tkeep,
                       tuser: axis_tuser, tlast: axis_tlast};
    assign push    = axis_tvalid & axis_tready;
    assign pop     = bk_valid & bk_ready;

    axis_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .push      (push),
        .push_beat (in_beat),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign bk_valid = (count != '0);
    assign bk_data  = head.tdata;
    assign bk_tstrb = head.tstrb;
    assign bk_tkeep = head.tkeep;
    assign bk_user  = head.tuser;
    assign bk_last  = head.tlast;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (push) state_next = axis_tlast ? DRAIN : RECV;
            RECV:    if (push && axis_tlast) state_next = DRAIN;
            DRAIN:   if (pop && bk_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    // Ready is registered from next-cycle occupancy and state, so a pop frees space one cycle later
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state       <= IDLE;
            axis_tready <= 1'b0;
            bk_done     <= 1'b0;
            bk_beat_cnt <= 8'd0;
        end else begin
            state       <= state_next;
            axis_tready <= (count_next != CW'(FIFO_DEPTH)) && (state_next != DRAIN);
            bk_done     <= pop & bk_last;
            if (push) begin
                if (state == IDLE)
                    bk_beat_cnt <= 8'd1;
                else if (bk_beat_cnt != 8'd255)
                    bk_beat_cnt <= bk_beat_cnt + 8'd1;
            end
        end
    end

`ifdef AXIS_SLAVE_TIMEOUT_EN
    logic [7:0] stall_cnt;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)
            stall_cnt <= 8'd0;
        else if (bk_valid && !bk_ready) begin
            if (stall_cnt != 8'd255) stall_cnt <= stall_cnt + 8'd1;
        end else
            stall_cnt <= 8'd0;
    end

    assign bk_nordy = (stall_cnt >= BK_RDY_TIMEOUT);
`else
    logic unused_timeout;
    assign unused_timeout = ^BK_RDY_TIMEOUT;
    assign bk_nordy       = 1'b0;
`endif

endmodule
